// File: rtl/dma_rd_burst_sequencer.sv
// Splits one DMA read command into AXI4 INCR AR bursts (4 KB safe, length capped) and
// tracks outstanding bursts until their final rlast. Optional DMA_RD_SEQ_STATS_EN adds stat_bursts.
module dma_rd_burst_sequencer #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned LEN_WIDTH       = 23,
  parameter int unsigned MAX_BURST       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_bytes,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  input  logic                  r_beat,
  input  logic                  m_axi_rlast,
  input  logic [1:0]            m_axi_rresp,
  output logic                  busy,
`ifdef DMA_RD_SEQ_STATS_EN
  output logic [15:0]           stat_bursts,
`endif
  output logic                  done_valid,
  output logic                  done_err
);

  localparam int unsigned ByteLanes = DATA_WIDTH / 8;
  localparam int unsigned SizeLog2  = $clog2(ByteLanes);
  localparam int unsigned OutW      = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  beats_left_q, beats_left_d;
  logic [OutW-1:0]       out_q, out_d;
  logic                  err_q, err_d;

  logic        bad_cmd;
  logic        ar_hs;
  logic        rlast_hit;
  logic [12:0] room_bytes;
  logic [31:0] room_beats;
  logic [31:0] burst_beats;

  // Misalignment and partial-word lengths are tested with masks so ByteLanes == 1 also works.
  assign bad_cmd = ((cmd_addr & ADDR_WIDTH'(ByteLanes - 1)) != '0) || (cmd_bytes == '0) ||
                   ((cmd_bytes & LEN_WIDTH'(ByteLanes - 1)) != '0);

  always_comb begin
    room_bytes  = 13'h1000 - {1'b0, addr_q[11:0]};
    room_beats  = 32'(room_bytes >> SizeLog2);
    burst_beats = 32'(beats_left_q);
    if (MAX_BURST < burst_beats) begin
      burst_beats = MAX_BURST;
    end
    if (room_beats < burst_beats) begin
      burst_beats = room_beats;
    end
  end

  assign m_axi_araddr  = addr_q;
  // Outside ISSUE beats_left is zero; hold arlen at 0 rather than wrapping to 255.
  assign m_axi_arlen   = (burst_beats == 32'd0) ? 8'd0 : 8'(burst_beats - 32'd1);
  assign m_axi_arsize  = 3'(SizeLog2);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = (state_q == StIssue) && (32'(out_q) < MAX_OUTSTANDING);

  assign ar_hs     = m_axi_arvalid & m_axi_arready;
  // A stray rlast with nothing outstanding is dropped so the counter cannot underflow.
  assign rlast_hit = r_beat & m_axi_rlast & (out_q != '0);

  assign cmd_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign done_valid = (state_q == StDone);
  assign done_err   = (state_q == StDone) & err_q;

  always_comb begin
    out_d = out_q;
    if (ar_hs && !rlast_hit) begin
      out_d = out_q + OutW'(1);
    end else if (!ar_hs && rlast_hit) begin
      out_d = out_q - OutW'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beats_left_d = beats_left_q;
    err_d        = err_q;
    if (busy && r_beat && (m_axi_rresp != 2'b00)) begin
      err_d = 1'b1;
    end
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          if (bad_cmd) begin
            err_d        = 1'b1;
            beats_left_d = '0;
            state_d      = StDone;
          end else begin
            err_d        = 1'b0;
            beats_left_d = cmd_bytes >> SizeLog2;
            state_d      = StIssue;
          end
        end
      end
      StIssue: begin
        if (ar_hs) begin
          addr_d       = addr_q + ADDR_WIDTH'(burst_beats << SizeLog2);
          beats_left_d = beats_left_q - LEN_WIDTH'(burst_beats);
          if (beats_left_q == LEN_WIDTH'(burst_beats)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (out_d == '0) begin
          state_d = StDone;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      beats_left_q <= '0;
      out_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beats_left_q <= beats_left_d;
      out_q        <= out_d;
      err_q        <= err_d;
    end
  end

`ifdef DMA_RD_SEQ_STATS_EN
  logic [15:0] stat_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      stat_q <= '0;
    end else if (ar_hs && (stat_q != 16'hFFFF)) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign stat_bursts = stat_q;
`endif

endmodule
